// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int c_ADDR_W        = 64;
    localparam int c_DATA_W        = 64;
    localparam int c_MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Round-robin, burst-capped arbiter between the load/store unit
//                (port 0) and the host loader (port 1) for a single-port memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = c_MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [c_ADDR_W-1:0] p0_addr,
    input  logic [c_DATA_W-1:0] p0_wdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [c_ADDR_W-1:0] p1_addr,
    input  logic [c_DATA_W-1:0] p1_wdata,
    output logic                p0_gnt,
    output logic                p1_gnt,
    output logic                p0_rvalid,
    output logic                p1_rvalid,
    output logic [c_DATA_W-1:0] p0_rdata,
    output logic [c_DATA_W-1:0] p1_rdata,
    output logic                mem_write,
    output logic                mem_read,
    output logic [c_ADDR_W-1:0] mem_address,
    output logic [c_DATA_W-1:0] mem_write_data,
    input  logic [c_DATA_W-1:0] mem_out
);

    localparam int                  c_BEAT_W    = $clog2(MAX_BURST + 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(MAX_BURST - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_MAX  = c_BEAT_W'(MAX_BURST);

    arb_state_e          r_state;
    logic                r_favor;
    logic [c_BEAT_W-1:0] r_beats;
    logic                r_p0_rvalid;
    logic                r_p1_rvalid;
    logic [c_DATA_W-1:0] r_p0_rdata;
    logic [c_DATA_W-1:0] r_p1_rdata;

    logic w_beat0;
    logic w_beat1;
    logic w_load0;
    logic w_load1;
    logic w_cap;

    // Gating with rst keeps the strobes quiet so the memory preload survives.
    assign w_beat0 = (r_state == ST_OWN0) && p0_req && !rst;
    assign w_beat1 = (r_state == ST_OWN1) && p1_req && !rst;
    assign w_load0 = w_beat0 && !p0_we;
    assign w_load1 = w_beat1 && !p1_we;
    assign w_cap   = (r_beats >= c_BEAT_LAST);

    assign p0_gnt    = w_beat0;
    assign p1_gnt    = w_beat1;
    assign p0_rvalid = r_p0_rvalid && !rst;
    assign p1_rvalid = r_p1_rvalid && !rst;
    assign p0_rdata  = r_p0_rdata;
    assign p1_rdata  = r_p1_rdata;

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (w_beat0) begin
            mem_read       = !p0_we;
            mem_write      = p0_we;
            mem_address    = p0_addr;
            mem_write_data = p0_wdata;
        end else if (w_beat1) begin
            mem_read       = !p1_we;
            mem_write      = p1_we;
            mem_address    = p1_addr;
            mem_write_data = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_favor <= 1'b0;
            r_beats <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beats <= '0;
                    if (p0_req && (!p1_req || !r_favor)) begin
                        r_state <= ST_OWN0;
                    end else if (p1_req) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if (!p0_req || (p1_req && w_cap)) begin
                        r_state <= p1_req ? ST_OWN1 : ST_IDLE;
                        r_favor <= 1'b1;
                        r_beats <= '0;
                    end else begin
                        r_beats <= (r_beats == c_BEAT_MAX) ? c_BEAT_MAX : r_beats + 1'b1;
                    end
                end
                ST_OWN1: begin
                    if (!p1_req || (p0_req && w_cap)) begin
                        r_state <= p0_req ? ST_OWN0 : ST_IDLE;
                        r_favor <= 1'b0;
                        r_beats <= '0;
                    end else begin
                        r_beats <= (r_beats == c_BEAT_MAX) ? c_BEAT_MAX : r_beats + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beats <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_load0;
            if (w_load0) begin
                r_p0_rdata <= mem_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_rvalid <= 1'b0;
            r_p1_rdata  <= '0;
        end else begin
            r_p1_rvalid <= w_load1;
            if (w_load1) begin
                r_p1_rdata <= mem_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_port_arbiter
//  Description : Vector-table bench for dmem_port_arbiter with a load-data queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [63:0] a0;
        logic [63:0] d0;
        logic        r1;
        logic        w1;
        logic [63:0] a1;
        logic [63:0] d1;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [63:0] ld;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [63:0] p0_rdata, p1_rdata;
    logic        mem_write, mem_read;
    logic [63:0] mem_address, mem_write_data, mem_out;

    logic [63:0] mem [0:255];
    vec_t        vecs[$];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          checks;
    int          errors;

    dmem_port_arbiter #(.MAX_BURST(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p0_gnt         (p0_gnt),
        .p1_gnt         (p1_gnt),
        .p0_rvalid      (p0_rvalid),
        .p1_rvalid      (p1_rvalid),
        .p0_rdata       (p0_rdata),
        .p1_rdata       (p1_rdata),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_out        (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: preload on reset, then a write in the same edge would win.
    assign mem_out = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (rst) begin
            mem[73] <= 64'h8;
            mem[74] <= 64'hA;
            mem[75] <= 64'hFFFF_FFFF_FFFF_FFFE;
            mem[76] <= 64'h10;
            mem[77] <= 64'h0;
        end
        if (mem_write) begin
            mem[mem_address[9:2]] <= mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst_i, input logic r0, input logic w0,
                                input logic [63:0] a0, input logic [63:0] d0,
                                input logic r1, input logic w1,
                                input logic [63:0] a1, input logic [63:0] d1,
                                input logic [1:0] gnt, input logic [1:0] rv,
                                input logic [63:0] ld);
        vec_t v;
        v.rst = rst_i; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.gnt = gnt; v.rv = rv; v.ld = ld;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
        logic        exp_rd;
        logic        exp_wr;
        @(posedge clk);
        #1;
        rst = v.rst;
        p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
        @(negedge clk);
        exp_addr = 64'h0; exp_wd = 64'h0; exp_rd = 1'b0; exp_wr = 1'b0;
        if (v.gnt[0]) begin
            exp_addr = v.a0; exp_wd = v.d0; exp_rd = !v.w0; exp_wr = v.w0;
        end else if (v.gnt[1]) begin
            exp_addr = v.a1; exp_wd = v.d1; exp_rd = !v.w1; exp_wr = v.w1;
        end
        chk($sformatf("v%0d p0_gnt", idx), {63'h0, p0_gnt}, {63'h0, v.gnt[0]});
        chk($sformatf("v%0d p1_gnt", idx), {63'h0, p1_gnt}, {63'h0, v.gnt[1]});
        chk($sformatf("v%0d p0_rvalid", idx), {63'h0, p0_rvalid}, {63'h0, v.rv[0]});
        chk($sformatf("v%0d p1_rvalid", idx), {63'h0, p1_rvalid}, {63'h0, v.rv[1]});
        chk($sformatf("v%0d mem_read", idx), {63'h0, mem_read}, {63'h0, exp_rd});
        chk($sformatf("v%0d mem_write", idx), {63'h0, mem_write}, {63'h0, exp_wr});
        chk($sformatf("v%0d mem_address", idx), mem_address, exp_addr);
        chk($sformatf("v%0d mem_write_data", idx), mem_write_data, exp_wd);
        if (p0_rvalid) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d p0_rvalid unexpected actual=1 required=0", idx);
            end else begin
                chk($sformatf("v%0d p0_rdata", idx), p0_rdata, q0.pop_front());
            end
        end
        if (p1_rvalid) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d p1_rvalid unexpected actual=1 required=0", idx);
            end else begin
                chk($sformatf("v%0d p1_rdata", idx), p1_rdata, q1.pop_front());
            end
        end
        if (v.rst) begin
            q0.delete();
            q1.delete();
        end
        if (v.gnt[0] && !v.w0) q0.push_back(v.ld);
        if (v.gnt[1] && !v.w1) q1.push_back(v.ld);
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] prev_g;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

        // Preload read from port 0
        add(mk(0, 1,0,64'h124,0, 0,0,0,0, 2'b00, 2'b00, 0));
        add(mk(0, 1,0,64'h124,0, 0,0,0,0, 2'b01, 2'b00, 64'h8));
        add(mk(0, 1,0,64'h12C,0, 0,0,0,0, 2'b01, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE));
        add(mk(0, 0,0,0,0,       0,0,0,0, 2'b00, 2'b01, 0));
        // Store then load on port 1
        add(mk(0, 0,0,0,0, 1,1,64'h40,64'hDEAD_BEEF, 2'b00, 2'b00, 0));
        add(mk(0, 0,0,0,0, 1,1,64'h40,64'hDEAD_BEEF, 2'b10, 2'b00, 0));
        add(mk(0, 0,0,0,0, 1,0,64'h40,0,             2'b10, 2'b00, 64'hDEAD_BEEF));
        add(mk(0, 0,0,0,0, 0,0,0,0,                  2'b00, 2'b10, 0));
        // Simultaneous first request, handover without idle
        add(mk(0, 1,0,64'h124,0, 1,0,64'h12C,0, 2'b00, 2'b00, 0));
        add(mk(0, 1,0,64'h124,0, 1,0,64'h12C,0, 2'b01, 2'b00, 64'h8));
        add(mk(0, 0,0,0,0,       1,0,64'h12C,0, 2'b00, 2'b01, 0));
        add(mk(0, 0,0,0,0,       1,0,64'h12C,0, 2'b10, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE));
        add(mk(0, 0,0,0,0,       0,0,0,0,       2'b00, 2'b10, 0));
        // Burst cap: 4 beats each, both requesting continuously
        add(mk(0, 1,0,64'h124,0, 1,1,64'h80,64'h1234, 2'b00, 2'b00, 0));
        prev_g = 2'b00;
        for (int k = 0; k < 12; k++) begin
            g = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
            add(mk(0, 1,0,64'h124,0, 1,1,64'h80,64'h1234, g,
                   (prev_g == 2'b01) ? 2'b01 : 2'b00, (g == 2'b01) ? 64'h8 : 64'h0));
            prev_g = g;
        end
        add(mk(0, 0,0,0,0, 0,0,0,0, 2'b00, (prev_g == 2'b01) ? 2'b01 : 2'b00, 0));
        // Idle stretch
        for (int k = 0; k < 10; k++) begin
            add(mk(0, 0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 0));
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset p0_gnt", {63'h0, p0_gnt}, 64'h0);
        chk("reset p1_gnt", {63'h0, p1_gnt}, 64'h0);
        chk("reset rvalid", {62'h0, p0_rvalid, p1_rvalid}, 64'h0);
        chk("reset p0_rdata", p0_rdata, 64'h0);
        chk("reset p1_rdata", p1_rdata, 64'h0);
        chk("reset strobes", {62'h0, mem_read, mem_write}, 64'h0);
        chk("reset mem_address", mem_address, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end
        chk("idle hold p0_rdata", p0_rdata, 64'h8);
        chk("idle hold p1_rdata", p1_rdata, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset mid-burst: store in the reset cycle must be dropped
        run_vec(mk(0, 1,0,64'h124,0,  0,0,0,0, 2'b00, 2'b00, 0), 100);
        run_vec(mk(0, 1,0,64'h124,0,  0,0,0,0, 2'b01, 2'b00, 64'h8), 101);
        run_vec(mk(1, 1,1,64'h128,64'h55, 0,0,0,0, 2'b00, 2'b00, 0), 102);
        run_vec(mk(0, 1,0,64'h128,0,  0,0,0,0, 2'b00, 2'b00, 0), 103);
        run_vec(mk(0, 1,0,64'h128,0,  0,0,0,0, 2'b01, 2'b00, 64'hA), 104);
        run_vec(mk(0, 0,0,0,0,        0,0,0,0, 2'b00, 2'b01, 0), 105);
        chk("word 74 after reset", mem[74], 64'hA);
        chk("p1_rdata cleared by reset", p1_rdata, 64'h0);
        chk("p0 queue drained", 64'(q0.size()), 64'h0);
        chk("p1 queue drained", 64'(q1.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
